// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encodings, defaults, address width.
// State ST_CSUM exists only when PROG_LOADER_CSUM_EN is defined.
package loader_defs;

   localparam int         ADDR_W         = 4;
   localparam int         IMEM_DEPTH_DEF = 16;
   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM = 3'd5,
`endif
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   // A frame length is usable only if it fits the instruction memory and is non-zero.
   function automatic logic len_ok(input logic [7:0] n, input int depth);
      return (n != 8'd0) && (int'(n) <= depth);
   endfunction

endpackage

// File: rtl/prog_loader_checksum.sv
// Mod-256 running sum of frame payload bytes; built only when PROG_LOADER_CSUM_EN is defined.
`ifdef PROG_LOADER_CSUM_EN
module prog_checksum
   import loader_defs::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       add_en,
   input  logic [7:0] data,
   output logic [7:0] sum
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum <= 8'd0;
      end else if (clear) begin
         sum <= 8'd0;
      end else if (add_en) begin
         sum <= sum + data;
      end
   end

endmodule
`endif

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/length/payload frames into instruction-memory writes.
// Optional trailing checksum byte is enabled by defining PROG_LOADER_CSUM_EN.
module prog_loader
   import loader_defs::*;
#(
   parameter int         IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [7:0]        imem_wdata,
   output logic              cpu_run,
   output logic              load_err,
   output logic              busy
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic              accept;
   logic              we_d;

   assign accept = in_valid && in_ready;

`ifdef PROG_LOADER_CSUM_EN
   logic       acc_clear;
   logic       acc_add;
   logic [7:0] acc_sum;

   prog_checksum u_checksum (
      .clk    (clk),
      .reset  (reset),
      .clear  (acc_clear),
      .add_en (acc_add),
      .data   (in_data),
      .sum    (acc_sum)
   );
`endif

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      we_d     = 1'b0;
      busy     = 1'b0;
      cpu_run  = 1'b0;
      load_err = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      acc_clear = 1'b0;
      acc_add   = 1'b0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (accept && in_data == SYNC_BYTE) state_d = ST_LEN;
         end
         ST_LEN: begin
            busy = 1'b1;
            if (accept) begin
               if (len_ok(in_data, IMEM_DEPTH)) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
                  // Store N-1 so a length of 16 still fits the 4-bit counter range.
                  last_d  = in_data[ADDR_W-1:0] - ADDR_W'(1);
`ifdef PROG_LOADER_CSUM_EN
                  acc_clear = 1'b1;
`endif
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_DATA: begin
            busy = 1'b1;
            if (accept) begin
               we_d = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
               acc_add = 1'b1;
`endif
               if (cnt_q == last_q) begin
`ifdef PROG_LOADER_CSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
`ifdef PROG_LOADER_CSUM_EN
         ST_CSUM: begin
            busy = 1'b1;
            if (accept) state_d = (in_data == acc_sum) ? ST_DONE : ST_ERR;
         end
`endif
         ST_DONE: begin
            cpu_run = 1'b1;
            if (accept && in_data == SYNC_BYTE) state_d = ST_LEN;
         end
         ST_ERR: begin
            load_err = 1'b1;
            if (accept && in_data == SYNC_BYTE) state_d = ST_LEN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Ready drops for the single cycle after each accepted byte, limiting intake to one byte per two cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 8'd0;
      end else begin
         in_ready <= !accept;
         imem_we  <= we_d;
         if (we_d) begin
            imem_addr  <= cnt_q;
            imem_wdata <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: byte-level frame model plus directed literal checks.
// Adapts frame format to PROG_LOADER_CSUM_EN.
module tb_prog_loader;

   localparam logic [7:0] SYNC  = 8'hA5;
   localparam int         DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_ready;
   logic       imem_we;
   logic [3:0] imem_addr;
   logic [7:0] imem_wdata;
   logic       cpu_run;
   logic       load_err;
   logic       busy;

   prog_loader dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .load_err   (load_err),
      .busy       (busy)
   );

   initial forever #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit streaming = 1'b0;

   typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
   wr_t wr_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: what the loader must report after each accepted byte.
   bit         m_busy, m_run, m_err;
   int         m_need;
   int         m_addr;
   logic [7:0] m_sum;
   logic       e_ready, e_we;
   logic [3:0] e_addr;
   logic [7:0] e_wdata;

   function automatic void model_reset();
      m_busy = 0; m_run = 0; m_err = 0; m_need = 0; m_addr = 0; m_sum = 8'd0;
      e_ready = 1'b0; e_we = 1'b0; e_addr = 4'd0; e_wdata = 8'd0;
   endfunction

   function automatic void model_apply(input logic [7:0] b);
      if (!m_busy) begin
         if (b == SYNC) begin
            m_busy = 1; m_run = 0; m_err = 0; m_need = -1;
         end
      end else if (m_need < 0) begin
         if (b == 8'd0 || int'(b) > DEPTH) begin
            m_busy = 0; m_err = 1;
         end else begin
            m_need = int'(b); m_addr = 0; m_sum = 8'd0;
         end
      end else if (m_need > 0) begin
         e_we = 1'b1; e_addr = m_addr[3:0]; e_wdata = b;
         m_addr++; m_sum = m_sum + b; m_need--;
`ifndef PROG_LOADER_CSUM_EN
         if (m_need == 0) begin
            m_busy = 0; m_run = 1;
         end
`endif
      end else begin
         m_busy = 0;
         if (b == m_sum) m_run = 1;
         else m_err = 1;
      end
   endfunction

   // Compare process: outputs are checked every falling edge against the model.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (reset) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_imem_we", imem_we, 0);
            check("rst_imem_addr", imem_addr, 0);
            check("rst_imem_wdata", imem_wdata, 0);
            check("rst_cpu_run", cpu_run, 0);
            check("rst_load_err", load_err, 0);
            check("rst_busy", busy, 0);
            model_reset();
         end else begin
            check("in_ready", in_ready, e_ready);
            check("imem_we", imem_we, e_we);
            check("imem_addr", imem_addr, e_addr);
            check("imem_wdata", imem_wdata, e_wdata);
            check("busy", busy, m_busy);
            check("cpu_run", cpu_run, m_run);
            check("load_err", load_err, m_err);
            if (imem_we === 1'b1) wr_log.push_back('{imem_addr, imem_wdata});
            e_we    = 1'b0;
            e_ready = !(in_valid && in_ready);
            if (in_valid && in_ready) model_apply(in_data);
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Present one byte and hold it until accepted; returns 1 time unit after the accepting edge.
   task automatic send(input logic [7:0] b);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int w = 0; w < 20 && !ok; w++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      check("send_accepted", ok, 1);
      if (!streaming) in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_csum(input logic [7:0] s);
`ifdef PROG_LOADER_CSUM_EN
      send(s);
`else
      if (s === 8'hxx) send(8'h00);
`endif
   endtask

   initial begin
      logic [7:0] s;
      int         prev;
      int         n;
      logic [7:0] b;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

      // Three-word frame: writes (0,11),(1,22),(2,33)
      wr_log.delete();
      send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
      send_csum(8'h66);
      idle(3);
      check("f1_nwrites", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         check("f1_w0", {wr_log[0].a, wr_log[0].d}, 12'h011);
         check("f1_w1", {wr_log[1].a, wr_log[1].d}, 12'h122);
         check("f1_w2", {wr_log[2].a, wr_log[2].d}, 12'h233);
      end
      check("f1_cpu_run", cpu_run, 1);
      check("f1_load_err", load_err, 0);

`ifdef PROG_LOADER_CSUM_EN
      // Bad checksum rejected, then a good reload recovers
      send(SYNC); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
      idle(2);
      check("badcs_err", load_err, 1);
      check("badcs_run", cpu_run, 0);
      send(SYNC); send(8'h01); send(8'h07); send(8'h07);
      idle(2);
      check("goodcs_err", load_err, 0);
      check("goodcs_run", cpu_run, 1);
`endif

      // Garbage ignored, then zero and oversize lengths rejected
      send(8'h00); send(8'hFF);
      check("garbage_busy", busy, 0);
      send(SYNC);
      check("sync_busy", busy, 1);
      send(8'h00);
      check("len0_err", load_err, 1);
      send(SYNC); send(8'h11);
      check("len17_err", load_err, 1);
      check("len17_busy", busy, 0);
      idle(2);

      // Full-depth frame streamed with valid held high
      wr_log.delete();
      streaming = 1'b1;
      s = 8'd0;
      send(SYNC); send(8'h10);
      prev = cyc;
      for (int i = 0; i < 16; i++) begin
         b = 8'(i * 7 + 3);
         s = s + b;
         send(b);
         check("stream_gap", cyc - prev, 2);
         check("stream_ready_low", in_ready, 0);
         prev = cyc;
      end
      send_csum(s);
      streaming = 1'b0;
      idle(3);
      check("f16_nwrites", wr_log.size(), 16);
      for (int i = 0; i < wr_log.size() && i < 16; i++) check("f16_addr", wr_log[i].a, i);
      check("f16_cpu_run", cpu_run, 1);

      // Reload from DONE, then reset during payload
      send(SYNC);
      check("reload_run", cpu_run, 0);
      check("reload_busy", busy, 1);
      send(8'h02); send(8'h01);
      #2 reset = 1'b1;
      #1;
      check("async_we", imem_we, 0);
      check("async_addr", imem_addr, 0);
      check("async_busy", busy, 0);
      check("async_ready", in_ready, 0);
      check("async_run", cpu_run, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("post_rst_ready", in_ready, 0);
      @(posedge clk);
      #1;
      check("first_edge_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);

      // Randomized frames against the model
      for (int f = 0; f < 40; f++) begin
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            b = 8'($urandom);
            if (b == SYNC) b = b ^ 8'h01;
            send(b);
         end
         streaming = ($urandom_range(0, 1) == 1);
         send(SYNC);
         if ($urandom_range(0, 9) == 0) begin
            n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
            send(8'(n));
         end else begin
            n = $urandom_range(1, 16);
            send(8'(n));
            s = 8'd0;
            for (int i = 0; i < n; i++) begin
               b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
               s = s + b;
               send(b);
               if (!streaming && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
            if ($urandom_range(0, 3) == 0) s = s ^ 8'h5A;
            send_csum(s);
         end
         streaming = 1'b0;
         idle($urandom_range(1, 3));
      end

      idle(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 16, the number of instruction-memory words (4-bit address).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the host byte is valid.
REQ-006 SHALL have port in_data, input, 8 bits: the host byte.
REQ-007 SHALL have port in_ready, output, 1 bit: the loader accepts a byte; a byte is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-008 SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 SHALL have port imem_addr, output, 4 bits: instruction-memory write address.
REQ-010 SHALL have port imem_wdata, output, 8 bits: instruction word to write.
REQ-011 SHALL have port cpu_run, output, 1 bit: program loaded; the CPU may leave reset.
REQ-012 SHALL have port load_err, output, 1 bit: the last frame was rejected.
REQ-013 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-014 SHALL use a frame of: SYNC_BYTE, then length N, then N instruction bytes, then one checksum byte (checksum only when configured).
REQ-015 SHALL have FSM states IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-016 IDLE: SHALL discard accepted bytes other than SYNC_BYTE; an accepted SYNC_BYTE SHALL move the FSM to LEN.
REQ-017 LEN: N in 1..IMEM_DEPTH SHALL move to DATA with the address counter at 0; N=0 or N>IMEM_DEPTH SHALL move to ERR.
REQ-018 DATA: each accepted byte SHALL produce, in the following cycle, a one-cycle imem_we=1 with imem_addr=counter and imem_wdata=byte (1-cycle latency); the counter SHALL then increment.
REQ-019 After the Nth data byte the FSM SHALL move to CSUM when checksum is enabled, otherwise to DONE; the counter SHALL never wrap (max value N-1).
REQ-020 in_ready SHALL be registered, SHALL be 1 in every state, and SHALL be driven to 0 for exactly the one cycle after each accepted byte, giving a maximum rate of 1 byte per 2 cycles.
REQ-021 DONE: cpu_run SHALL be 1 and busy 0; an accepted SYNC_BYTE SHALL clear cpu_run in the next cycle and move to LEN (reload); other bytes SHALL be ignored.
REQ-022 ERR: load_err SHALL be 1, cpu_run 0 and busy 0; an accepted SYNC_BYTE SHALL clear load_err and move to LEN.
REQ-023 busy SHALL be 1 exactly in LEN, DATA and CSUM.
REQ-024 A SYNC_BYTE value received in DATA or CSUM SHALL be treated as payload, with no resynchronisation.
REQ-025 in_valid=1 while in_ready=0 SHALL NOT consume the byte; the host holds it.

Reset
REQ-026 reset=1 SHALL immediately force: state IDLE, counter 0, checksum accumulator 0, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_run 0, load_err 0, busy 0.
REQ-027 in_ready SHALL rise to 1 on the first clk edge after reset deasserts.
REQ-028 Reset mid-frame SHALL abandon the frame; partially written memory contents are don't-care.

Configuration
REQ-029 Macro PROG_LOADER_CSUM_EN defined: the accumulator SHALL sum data bytes mod 256; in CSUM a matching byte SHALL move to DONE and a mismatching byte to ERR.
REQ-030 Macro PROG_LOADER_CSUM_EN undefined: the CSUM state and accumulator SHALL be absent, and DATA SHALL move directly to DONE.

Structure
REQ-031 A shared package loader_defs SHALL hold the state encodings, SYNC_BYTE default, IMEM_DEPTH default and address width 4.
REQ-032 One sub-module, prog_checksum (clear, add-enable, 8-bit byte, 8-bit sum), SHALL be instantiated only under PROG_LOADER_CSUM_EN.

Verification
REQ-033 Frame A5,03,11,22,33,66 (CSUM_EN) -> writes (0,11),(1,22),(2,33), each 1 cycle after acceptance; then cpu_run=1, load_err=0.
REQ-034 Frame A5,02,10,20,31 (CSUM_EN) -> two writes, then load_err=1, cpu_run=0; next A5,01,07,07 -> load_err=0, cpu_run=1.
REQ-035 Bytes 00,FF,A5,00 -> first two ignored, then ERR (length 0); A5,11 -> ERR (length 17 > 16).
REQ-036 Frame of length 16 -> addresses 0..15 written once each, no 17th write, cpu_run=1.
REQ-037 In DONE, send A5 -> cpu_run=0 next cycle and busy=1; reset asserted during DATA -> all outputs 0 asynchronously and state IDLE.
REQ-038 in_valid held high continuously -> in_ready toggles 1,0,1,0 and exactly one byte is accepted per two cycles.
